// File: rtl/aibnd_clkgate_pkg.sv
// Shared types and constants for the AIB slave clock-gate controller.
package aibnd_clkgate_pkg;

    typedef enum logic [1:0] {
        StGated  = 2'd0,
        StUngate = 2'd1,
        StRun    = 2'd2,
        StIdle   = 2'd3
    } state_e;

    // Polarity of the aibnd_nor2 enable pin.
    localparam logic GATE_CLOSED = 1'b1;
    localparam logic GATE_OPEN   = 1'b0;

endpackage

// File: rtl/aibnd_clkgate_if.sv
// Request/ack bundle between clock requesters and the clock-gate controller.
interface aibnd_clkgate_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic               force_on;
    logic               gate_en;
    logic [NUM_REQ-1:0] clk_ack;
    logic               clk_active;

    modport master (
        output req,
        output force_on,
        input  gate_en,
        input  clk_ack,
        input  clk_active
    );

    modport slave (
        input  req,
        input  force_on,
        output gate_en,
        output clk_ack,
        output clk_active
    );
endinterface

// File: rtl/aibnd_clkgate_cnt.sv
// Loadable down counter shared by the settle and idle phases; saturates at zero.
module aibnd_clkgate_cnt #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/aibnd_clkgate_ctrl.sv
// Drives the aibnd_nor2 enable: ungate on request, settle before ack, hold off before re-gating.
module aibnd_clkgate_ctrl
    import aibnd_clkgate_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned IDLE_CYC   = 16,
    parameter int unsigned CNT_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vccl_aibnd,
    input  logic              vssl_aibnd,
    aibnd_clkgate_if.slave    bus
);

    if (NUM_REQ < 1 || NUM_REQ > 8 || SETTLE_CYC < 1 || IDLE_CYC < 1 ||
        (SETTLE_CYC - 1) >= (1 << CNT_W) || (IDLE_CYC - 1) >= (1 << CNT_W)) begin : g_param_chk
        $error("aibnd_clkgate_ctrl: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] IdleLoad   = CNT_W'(IDLE_CYC - 1);

    // Supply pins carry no logic function.
    logic unused_pwr;
    assign unused_pwr = vccl_aibnd ^ vssl_aibnd;

    state_e             state_q, state_d;
    logic               gate_en_q, gate_en_d;
    logic [NUM_REQ-1:0] clk_ack_q, clk_ack_d;
    logic               clk_active_q, clk_active_d;
    logic               cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               any_req;

    assign any_req = (|bus.req) | bus.force_on;

    aibnd_clkgate_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        gate_en_d    = gate_en_q;
        clk_ack_d    = clk_ack_q;
        clk_active_d = clk_active_q;
        cnt_load     = 1'b0;
        cnt_load_val = SettleLoad;
        cnt_dec      = 1'b0;

        case (state_q)
            StGated: begin
                gate_en_d    = GATE_CLOSED;
                clk_ack_d    = '0;
                clk_active_d = 1'b0;
                if (any_req) begin
                    state_d      = StUngate;
                    gate_en_d    = GATE_OPEN;
                    cnt_load     = 1'b1;
                    cnt_load_val = SettleLoad;
                end
            end
            StUngate: begin
                // Settle delay always runs to completion, even if requests vanish.
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    clk_active_d = 1'b1;
                    if (any_req) begin
                        state_d   = StRun;
                        clk_ack_d = bus.req;
                    end else begin
                        state_d      = StIdle;
                        cnt_load     = 1'b1;
                        cnt_load_val = IdleLoad;
                    end
                end
            end
            StRun: begin
                if (any_req) begin
                    clk_ack_d = bus.req;
                end else begin
                    state_d      = StIdle;
                    clk_ack_d    = '0;
                    cnt_load     = 1'b1;
                    cnt_load_val = IdleLoad;
                end
            end
            StIdle: begin
                // A request on the expiry edge wins over re-gating.
                if (any_req) begin
                    state_d   = StRun;
                    clk_ack_d = bus.req;
                end else if (cnt_zero) begin
                    state_d      = StGated;
                    gate_en_d    = GATE_CLOSED;
                    clk_active_d = 1'b0;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d      = StGated;
                gate_en_d    = GATE_CLOSED;
                clk_ack_d    = '0;
                clk_active_d = 1'b0;
            end
        endcase
    end

    // gate_en only moves on a rising edge, while the NOR output is already held low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StGated;
            gate_en_q    <= GATE_CLOSED;
            clk_ack_q    <= '0;
            clk_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_en_q    <= gate_en_d;
            clk_ack_q    <= clk_ack_d;
            clk_active_q <= clk_active_d;
        end
    end

    assign bus.gate_en    = gate_en_q;
    assign bus.clk_ack    = clk_ack_q;
    assign bus.clk_active = clk_active_q;

endmodule

// File: tb/tb_aibnd_clkgate_ctrl.sv
// Table-driven self-checking bench for aibnd_clkgate_ctrl (defaults: 4 req, settle 4, idle 16).
module tb_aibnd_clkgate_ctrl;

    localparam int unsigned NR = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    aibnd_clkgate_if #(.NUM_REQ(NR)) bus ();

    aibnd_clkgate_ctrl #(
        .NUM_REQ    (NR),
        .SETTLE_CYC (4),
        .IDLE_CYC   (16),
        .CNT_W      (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vccl_aibnd (1'b1),
        .vssl_aibnd (1'b0),
        .bus        (bus)
    );

    typedef struct packed {
        logic          gate;
        logic [NR-1:0] ack;
        logic          act;
    } out_t;

    typedef struct packed {
        logic          rst;
        logic [NR-1:0] req;
        logic          fon;
        logic [7:0]    n;
        out_t          exp;
    } vec_t;

    vec_t tbl[$];
    out_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void add(input logic rst, input logic [NR-1:0] req, input logic fon,
                                input int n, input logic g, input logic [NR-1:0] a,
                                input logic act);
        tbl.push_back({rst, req, fon, 8'(n), g, a, act});
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare just after the edge.
    task automatic step(input logic rst, input logic [NR-1:0] req, input logic fon,
                        input out_t e, input int id, input int cyc);
        out_t got;
        out_t want;
        reset        = rst;
        bus.req      = req;
        bus.force_on = fon;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got  = {bus.gate_en, bus.clk_ack, bus.clk_active};
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL vec%0d cyc%0d: got gate_en=%b clk_ack=%b clk_active=%b, required gate_en=%b clk_ack=%b clk_active=%b",
                     id, cyc, got.gate, got.ack, got.act, want.gate, want.ack, want.act);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.req      = '0;
        bus.force_on = 1'b0;

        //  rst req     fon  n   gate ack     act
        add(1, 4'b0000, 0,  2,  1,   4'b0000, 0);  // reset values
        add(0, 4'b0000, 0, 50,  1,   4'b0000, 0);  // idle after reset
        add(0, 4'b0001, 0,  4,  0,   4'b0000, 0);  // settle window
        add(0, 4'b0001, 0,  5,  0,   4'b0001, 1);  // acked at k+SETTLE
        add(0, 4'b0011, 0,  3,  0,   4'b0011, 1);  // new requester, 1-cycle ack
        add(0, 4'b0010, 0,  2,  0,   4'b0010, 1);  // dropped requester
        add(0, 4'b0000, 0, 16,  0,   4'b0000, 1);  // idle hold-off
        add(0, 4'b0000, 0,  3,  1,   4'b0000, 0);  // re-gated at m+IDLE
        add(0, 4'b0001, 0,  4,  0,   4'b0000, 0);
        add(0, 4'b0001, 0,  2,  0,   4'b0001, 1);
        add(0, 4'b0000, 0,  5,  0,   4'b0000, 1);  // inside idle window
        add(0, 4'b0100, 0,  3,  0,   4'b0100, 1);  // wake without settle
        add(0, 4'b0000, 0, 16,  0,   4'b0000, 1);
        add(0, 4'b1000, 0,  2,  0,   4'b1000, 1);  // request on expiry edge wins
        add(0, 4'b0000, 0, 16,  0,   4'b0000, 1);
        add(0, 4'b0000, 0,  2,  1,   4'b0000, 0);
        add(0, 4'b0000, 1,  4,  0,   4'b0000, 0);  // force_on only
        add(0, 4'b0000, 1,  3,  0,   4'b0000, 1);
        add(0, 4'b0000, 0, 16,  0,   4'b0000, 1);
        add(0, 4'b0000, 0,  2,  1,   4'b0000, 0);
        add(0, 4'b0001, 0,  1,  0,   4'b0000, 0);  // request gone during settle
        add(0, 4'b0000, 0,  3,  0,   4'b0000, 0);
        add(0, 4'b0000, 0, 16,  0,   4'b0000, 1);
        add(0, 4'b0000, 0,  2,  1,   4'b0000, 0);

        foreach (tbl[i]) begin
            for (int c = 0; c < int'(tbl[i].n); c++) begin
                step(tbl[i].rst, tbl[i].req, tbl[i].fon, tbl[i].exp, i, c);
            end
        end

        // Reset while in UNGATE with the counter at 2, then a full settle again.
        step(0, 4'b0010, 0, '{gate: 1'b0, ack: 4'b0000, act: 1'b0}, 100, 0);
        step(0, 4'b0010, 0, '{gate: 1'b0, ack: 4'b0000, act: 1'b0}, 100, 1);
        step(1, 4'b0010, 0, '{gate: 1'b1, ack: 4'b0000, act: 1'b0}, 101, 0);
        for (int c = 0; c < 4; c++) begin
            step(0, 4'b0010, 0, '{gate: 1'b0, ack: 4'b0000, act: 1'b0}, 102, c);
        end
        step(0, 4'b0010, 0, '{gate: 1'b0, ack: 4'b0010, act: 1'b1}, 103, 0);

        // Reset from RUN.
        step(1, 4'b0010, 0, '{gate: 1'b1, ack: 4'b0000, act: 1'b0}, 104, 0);
        for (int c = 0; c < 3; c++) begin
            step(0, 4'b0000, 0, '{gate: 1'b1, ack: 4'b0000, act: 1'b0}, 105, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
